// File: rtl/regf_pkg.sv
// Shared types and defaults for the multi-port register file.
package regf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int XLEN_DEF   = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;

  // Returns field idx of a packed vector of width-bit fields (fields up to 32 bits).
  function automatic logic [31:0] get_field(input logic [127:0] vec, input int idx,
                                            input int width);
    logic [127:0] mask;
    mask = (128'(1) << width) - 128'(1);
    return 32'((vec >> (idx * width)) & mask);
  endfunction

endpackage

// File: rtl/regf_rdport.sv
// One registered read port: enable hold, zero while clearing, optional write-first
// bypass selected by REGF_BYPASS_EN.
module regf_rdport #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clear,
  input  logic            rd_en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            w_en,
  input  logic [AW-1:0]   w_addr,
  input  logic [XLEN-1:0] w_data,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] rd_data_q;
  logic [XLEN-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (clear) begin
      rd_data_d = '0;
    end else if (rd_en) begin
      if (addr == '0) begin
        rd_data_d = '0;
`ifdef REGF_BYPASS_EN
      end else if (w_en && (w_addr == addr)) begin
        rd_data_d = w_data;
`endif
      end else begin
        rd_data_d = mem_data;
      end
    end
  end

`ifndef REGF_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{w_en, w_addr, w_data};
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/regf_mp.sv
// Multi-read-port register file with post-reset clear sequencer and ready flag.
// Same-cycle write/read behaviour chosen by REGF_BYPASS_EN (write-first when defined).
module regf_mp
  import regf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic                   w_enable,
  input  logic [AW-1:0]          w_addr,
  input  logic [XLEN-1:0]        w_data,
  output logic                   ready
);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            clearing;
  logic            run_wr;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= CLEAR;
      clr_idx_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Entry 0 is never written, so it needs no clear; reads of it are forced to zero.
  always_comb begin
    clearing = (state_q == CLEAR);
    run_wr   = !clearing && w_enable && (w_addr != '0);
    mem_we   = rstn && (clearing || run_wr);
    mem_wa   = clearing ? clr_idx_q : w_addr;
    mem_wd   = clearing ? '0 : w_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] port_addr;
      assign port_addr = AW'(get_field(128'(rs_addr), gi, AW));

      regf_rdport #(
        .XLEN(XLEN),
        .AW  (AW)
      ) u_port (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (clearing),
        .rd_en   (rd_en[gi]),
        .addr    (port_addr),
        .mem_data(mem_q[port_addr]),
        .w_en    (run_wr),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .rd_data (rd_data[gi*XLEN +: XLEN])
      );
    end
  endgenerate

  assign ready = ready_q;

endmodule
